// File: rtl/icache_pkg.sv
// Shared constants, field-position helpers and FSM state encoding for the
// instruction cache and its refill controller.
package icache_pkg;

  localparam int OFFSET_WIDTH = 2;
  localparam int LINE_WIDTH   = 6;
  localparam int WORD_LSB     = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_DATA = 3'd3,
    ST_FILL      = 3'd4,
    ST_REPLAY    = 3'd5
  } state_e;

  // Lowest address bit of the line index field.
  function automatic int line_lsb(input int offset_width);
    return offset_width + WORD_LSB;
  endfunction

  // Lowest address bit of the tag field.
  function automatic int tag_lsb(input int offset_width, input int line_width);
    return offset_width + line_width + WORD_LSB;
  endfunction

endpackage

// File: rtl/icache_mem_if.sv
// Block-read request / word-response channel between the refill controller
// (master) and the memory side (slave).
interface icache_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/icache_block_assembler.sv
// Collects response beats into a full cache block; done pulses with the last beat.
module icache_block_assembler
  import icache_pkg::*;
#(
  parameter int offset_width = OFFSET_WIDTH,
  localparam int block_size = 1 << offset_width
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      beat_valid_i,
  input  logic [31:0]               beat_data_i,
  output logic [32*block_size-1:0]  block_o,
  output logic                      done_o
);

  logic [offset_width-1:0]  beat_q, beat_d;
  logic [32*block_size-1:0] block_q, block_d;

  always_comb begin
    beat_d  = beat_q;
    block_d = block_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (beat_valid_i) begin
      block_d[32*beat_q +: 32] = beat_data_i;
      beat_d = beat_q + 1'b1;   // wraps to 0 after the last word
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      beat_q  <= '0;
      block_q <= '0;
    end else begin
      beat_q  <= beat_d;
      block_q <= block_d;
    end
  end

  assign block_o = block_q;
  assign done_o  = beat_valid_i && !clear_i && (beat_q == offset_width'(block_size - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss handler: registered tag compare, block refill over the memory
// channel, single-cycle array fill, lookup replay and fence.i invalidation.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int offset_width = OFFSET_WIDTH,
  parameter int line_width   = LINE_WIDTH,
  localparam int tag_width   = 32 - tag_lsb(offset_width, line_width),
  localparam int block_size  = 1 << offset_width
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      fetch_valid_i,
  input  logic [31:0]               fetch_address_i,
  input  logic                      fence_i_i,
  output logic                      stall_o,
  output logic                      fetch_hit_o,
  output logic [31:0]               array_address_o,
  input  logic [tag_width-1:0]      array_tag_i,
  input  logic                      array_tag_valid_i,
  output logic                      write_in_o,
  output logic [line_width-1:0]     write_line_index_o,
  output logic [tag_width-1:0]      write_tag_o,
  output logic [32*block_size-1:0]  write_block_o,
  output logic                      invalidate_all_o,
  icache_mem_if.master              mem
);

  localparam int LINE_LO = line_lsb(offset_width);
  localparam int TAG_LO  = tag_lsb(offset_width, line_width);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        fence_pending_q, fence_pending_d;
  logic        inv_q, inv_d;
  logic        hit, req_fire, beat_valid, block_done;
  logic [32*block_size-1:0] block;

  assign hit        = array_tag_valid_i && (array_tag_i == addr_q[31:TAG_LO]);
  assign req_fire   = (state_q == ST_MISS_REQ) && mem.req_ready;
  assign beat_valid = (state_q == ST_MISS_DATA) && mem.resp_valid;

  icache_block_assembler #(.offset_width(offset_width)) u_asm (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .clear_i      (req_fire),
    .beat_valid_i (beat_valid),
    .beat_data_i  (mem.resp_data),
    .block_o      (block),
    .done_o       (block_done)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      fence_pending_q <= 1'b0;
      inv_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      fence_pending_q <= fence_pending_d;
      inv_q           <= inv_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    inv_d           = 1'b0;
    fence_pending_d = fence_pending_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_valid_i) begin
          addr_d  = fetch_address_i;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!hit)               state_d = ST_MISS_REQ;
        else if (fetch_valid_i) addr_d  = fetch_address_i;
        else                    state_d = ST_IDLE;
      end
      ST_MISS_REQ:  if (mem.req_ready) state_d = ST_MISS_DATA;
      ST_MISS_DATA: if (block_done)    state_d = ST_FILL;
      ST_FILL:      state_d = ST_REPLAY;
      ST_REPLAY:    state_d = ST_LOOKUP;
      default:      state_d = ST_IDLE;
    endcase
    // A fence during a refill is deferred so the fill lands before the wipe.
    if (state_q == ST_IDLE || state_q == ST_LOOKUP || state_q == ST_REPLAY)
      inv_d = fence_i_i;
    else if (fence_i_i)
      fence_pending_d = 1'b1;
    if (state_q == ST_REPLAY)
      fence_pending_d = 1'b0;
  end

  always_comb begin
    stall_o            = 1'b1;
    fetch_hit_o        = 1'b0;
    array_address_o    = addr_q;
    write_in_o         = 1'b0;
    write_line_index_o = '0;
    write_tag_o        = '0;
    mem.req_valid      = 1'b0;
    invalidate_all_o   = inv_q;
    case (state_q)
      ST_IDLE: begin
        stall_o         = 1'b0;
        array_address_o = fetch_address_i;
      end
      ST_LOOKUP: begin
        stall_o         = !hit;
        fetch_hit_o     = hit;
        array_address_o = fetch_address_i;
      end
      ST_MISS_REQ: mem.req_valid = 1'b1;
      ST_FILL: begin
        write_in_o         = 1'b1;
        write_line_index_o = addr_q[LINE_LO +: line_width];
        write_tag_o        = addr_q[31:TAG_LO];
      end
      ST_REPLAY: invalidate_all_o = inv_q | fence_pending_q;
      default: ;
    endcase
    if (!reset_i) begin
      stall_o          = 1'b0;
      fetch_hit_o      = 1'b0;
      array_address_o  = '0;
      write_in_o       = 1'b0;
      mem.req_valid    = 1'b0;
      invalidate_all_o = 1'b1;
    end
  end

  assign mem.req_addr  = {addr_q[31:LINE_LO], {LINE_LO{1'b0}}};
  assign write_block_o = block;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl with a behavioural cache array model.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch_valid, fence;
  logic [31:0]  fetch_address;
  logic         stall, fetch_hit, write_in, inv_all;
  logic [31:0]  array_address;
  logic [21:0]  rd_tag, write_tag;
  logic         rd_valid;
  logic [5:0]   write_line;
  logic [127:0] write_block;

  icache_mem_if mem();

  icache_refill_ctrl dut (
    .clock_i            (clk),
    .reset_i            (rst_n),
    .fetch_valid_i      (fetch_valid),
    .fetch_address_i    (fetch_address),
    .fence_i_i          (fence),
    .stall_o            (stall),
    .fetch_hit_o        (fetch_hit),
    .array_address_o    (array_address),
    .array_tag_i        (rd_tag),
    .array_tag_valid_i  (rd_valid),
    .write_in_o         (write_in),
    .write_line_index_o (write_line),
    .write_tag_o        (write_tag),
    .write_block_o      (write_block),
    .invalidate_all_o   (inv_all),
    .mem                (mem)
  );

  always #5 clk = ~clk;

  // Cache array model: registered read, updates visible to the same-edge read.
  logic [21:0] tag_mem [64];
  logic        val_mem [64];
  int          ri;
  always @(posedge clk) begin
    ri = int'(array_address[9:4]);
    if (inv_all) begin
      for (int i = 0; i < 64; i++) val_mem[i] = 1'b0;
    end else if (write_in) begin
      val_mem[write_line] = 1'b1;
      tag_mem[write_line] = write_tag;
    end
    rd_valid <= val_mem[ri];
    rd_tag   <= tag_mem[ri];
  end

  typedef enum {EV_REQ, EV_FILL, EV_INV, EV_HIT} ev_e;
  typedef struct {
    ev_e          kind;
    logic [31:0]  addr;
    logic [5:0]   line;
    logic [21:0]  tag;
    logic [127:0] blk;
    bit           need_prev;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input ev_e k, input logic [31:0] a, input logic [5:0] l,
                      input logic [21:0] t, input logic [31:0] base, input bit np);
    exp_t e;
    e.kind = k; e.addr = a; e.line = l; e.tag = t; e.need_prev = np;
    e.blk  = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    exp_q.push_back(e);
  endtask

  task automatic take(input ev_e k, output exp_t e, output bit ok);
    vectors++;
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event_order: got %s expected none", k.name());
    end else if (exp_q[0].kind != k) begin
      miscompares++;
      $display("FAIL event_order: got %s expected %s", k.name(), exp_q[0].kind.name());
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on every observable event.
  exp_t m_e;
  bit   m_ok, prev_hit, prev_write;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem.req_valid) begin
        if (exp_q.size() > 0 && exp_q[0].kind == EV_REQ) begin
          check("req_addr", mem.req_addr, exp_q[0].addr);
          check("req_stall", stall, 1);
        end
        if (mem.req_ready) take(EV_REQ, m_e, m_ok);
      end
      if (write_in) begin
        take(EV_FILL, m_e, m_ok);
        if (m_ok) begin
          check("fill_line", write_line, m_e.line);
          check("fill_tag", write_tag, m_e.tag);
          check("fill_block", write_block, m_e.blk);
        end
      end
      if (inv_all) begin
        take(EV_INV, m_e, m_ok);
        if (m_ok && m_e.need_prev) check("inv_after_fill", prev_write, 1);
      end
      if (fetch_hit) begin
        take(EV_HIT, m_e, m_ok);
        if (m_ok) begin
          check("hit_stall", stall, 0);
          check("hit_no_req", mem.req_valid, 0);
          if (m_e.need_prev) check("hit_consecutive", prev_hit, 1);
        end
      end
    end
    prev_hit   = fetch_hit && rst_n;
    prev_write = write_in && rst_n;
  end

  task automatic check_reset_outputs();
    check("rst_stall", stall, 0);
    check("rst_hit", fetch_hit, 0);
    check("rst_array_addr", array_address, 0);
    check("rst_write_in", write_in, 0);
    check("rst_req_valid", mem.req_valid, 0);
    check("rst_req_addr", mem.req_addr, 0);
    check("rst_block", write_block, 0);
    check("rst_inv_all", inv_all, 1);
  endtask

  task automatic do_fetch(input logic [31:0] a);
    fetch_valid = 1'b1; fetch_address = a;
    @(posedge clk); #1;
    fetch_valid = 1'b0;
  endtask

  task automatic serve_miss(input int req_delay, input int gap, input logic [31:0] base,
                            input int fence_beat, input int reset_beat);
    int n = 0;
    while (!mem.req_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!mem.req_valid) begin
      vectors++; miscompares++;
      $display("FAIL req_timeout: mem_req_valid=0 expected 1");
      return;
    end
    repeat (req_delay) begin @(posedge clk); #1; end
    mem.req_ready = 1'b1;
    @(posedge clk); #1;
    mem.req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem.resp_valid = 1'b1;
      mem.resp_data  = base + 32'(b);
      fence          = (b == fence_beat);
      if (b == reset_beat) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
      mem.resp_valid = 1'b0;
      fence          = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: %0d events outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_address = 32'h0000_1234; fence = 1'b0;
    mem.req_ready = 1'b0; mem.resp_valid = 1'b0; mem.resp_data = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    fetch_address = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    #1 check("post_rst_inv_all", inv_all, 0);

    // Cold miss at 0x1040: line 0x04, tag 0x4
    push(EV_REQ,  32'h0000_1040, 6'h00, 22'h0, 32'h0, 1'b0);
    push(EV_FILL, 32'h0,         6'h04, 22'h4, 32'hA0, 1'b0);
    push(EV_HIT,  32'h0,         6'h00, 22'h0, 32'h0, 1'b0);
    do_fetch(32'h0000_1040);
    serve_miss(0, 0, 32'hA0, -1, -1);
    drain();

    // Back-to-back hits in the filled line
    push(EV_HIT, 32'h0, 6'h00, 22'h0, 32'h0, 1'b0);
    push(EV_HIT, 32'h0, 6'h00, 22'h0, 32'h0, 1'b1);
    push(EV_HIT, 32'h0, 6'h00, 22'h0, 32'h0, 1'b1);
    fetch_valid = 1'b1; fetch_address = 32'h0000_1044; @(posedge clk); #1;
    fetch_address = 32'h0000_1048; @(posedge clk); #1;
    fetch_address = 32'h0000_104C; @(posedge clk); #1;
    fetch_valid = 1'b0;
    drain();

    // Conflict miss: 0x1440 maps to line 0x04 with tag 0x5
    push(EV_REQ,  32'h0000_1440, 6'h00, 22'h0, 32'h0, 1'b0);
    push(EV_FILL, 32'h0,         6'h04, 22'h5, 32'hB0, 1'b0);
    push(EV_HIT,  32'h0,         6'h00, 22'h0, 32'h0, 1'b0);
    do_fetch(32'h0000_1440);
    serve_miss(0, 0, 32'hB0, -1, -1);
    drain();

    // 0x1040 was evicted; refill under request and response backpressure
    push(EV_REQ,  32'h0000_1040, 6'h00, 22'h0, 32'h0, 1'b0);
    push(EV_FILL, 32'h0,         6'h04, 22'h4, 32'hC0, 1'b0);
    push(EV_HIT,  32'h0,         6'h00, 22'h0, 32'h0, 1'b0);
    do_fetch(32'h0000_1040);
    serve_miss(5, 2, 32'hC0, -1, -1);
    drain();

    // fence.i in IDLE: single invalidate pulse, then 0x1040 misses
    push(EV_INV, 32'h0, 6'h00, 22'h0, 32'h0, 1'b0);
    fence = 1'b1; @(posedge clk); #1; fence = 1'b0;
    drain();
    push(EV_REQ,  32'h0000_1040, 6'h00, 22'h0, 32'h0, 1'b0);
    push(EV_FILL, 32'h0,         6'h04, 22'h4, 32'hD0, 1'b0);
    push(EV_HIT,  32'h0,         6'h00, 22'h0, 32'h0, 1'b0);
    do_fetch(32'h0000_1040);
    serve_miss(0, 0, 32'hD0, -1, -1);
    drain();

    // fence.i during MISS_DATA at 0x3000 (line 0x00, tag 0xC): replay misses
    push(EV_REQ,  32'h0000_3000, 6'h00, 22'h0, 32'h0, 1'b0);
    push(EV_FILL, 32'h0,         6'h00, 22'hC, 32'hE0, 1'b0);
    push(EV_INV,  32'h0,         6'h00, 22'h0, 32'h0, 1'b1);
    push(EV_REQ,  32'h0000_3000, 6'h00, 22'h0, 32'h0, 1'b0);
    push(EV_FILL, 32'h0,         6'h00, 22'hC, 32'hF0, 1'b0);
    push(EV_HIT,  32'h0,         6'h00, 22'h0, 32'h0, 1'b0);
    do_fetch(32'h0000_3000);
    serve_miss(0, 0, 32'hE0, 1, -1);
    serve_miss(0, 0, 32'hF0, -1, -1);
    drain();

    // Reset during the 2nd beat at 0x2080; late beats must be ignored
    push(EV_REQ, 32'h0000_2080, 6'h00, 22'h0, 32'h0, 1'b0);
    do_fetch(32'h0000_2080);
    serve_miss(0, 0, 32'h40, -1, 1);
    drain();
    push(EV_REQ,  32'h0000_2080, 6'h00, 22'h0, 32'h0, 1'b0);
    push(EV_FILL, 32'h0,         6'h08, 22'h8, 32'h50, 1'b0);
    push(EV_HIT,  32'h0,         6'h00, 22'h0, 32'h0, 1'b0);
    do_fetch(32'h0000_2080);
    serve_miss(0, 0, 32'h50, -1, -1);
    drain();

    check("queue_empty", 128'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss-handling and refill controller that sits directly in front of the instruction-cache register array and owns that array's write port.
- Registers each fetch address and compares the array's registered tag/valid outputs against it. On a miss it stalls the front end, fetches the whole block from the memory side one word per beat, then writes line, tag and valid in a single cycle.
- It then replays the lookup and also sequences whole-cache invalidation (fence.i).

Parameters:
- offset_width, 2, log2 of instruction words per block; must match the cache array.
- line_width, 6, log2 of cache lines; must match the cache array.
- tag_width (localparam), 32-offset_width-line_width-2, tag bits.
- block_size (localparam), 1<<offset_width, words per block.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  front end presents fetch_address this cycle.
- fetch_address  in  32  byte address of the requested instruction.
- fence_i  in  1  one-cycle request to invalidate the whole cache.
- stall  out  1  front end must hold fetch_address and fetch_valid.
- fetch_hit  out  1  the array's instruction output is valid for the latched address this cycle.
- array_address  out  32  address driven to the cache array read port.
- array_tag  in  tag_width  registered tag from the array.
- array_tag_valid  in  1  registered valid bit from the array.
- write_in  out  1  array write strobe.
- write_line_index  out  line_width  line being filled.
- write_tag  out  tag_width  tag being filled.
- write_block  out  32*block_size  assembled block; word j sits at bits [32*j +: 32].
- invalidate_all  out  1  clears all array valid bits.
- mem_req_valid  out  1  block read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  32  block-aligned byte address; low offset_width+2 bits are 0.
- mem_resp_valid  in  1  one response word this cycle.
- mem_resp_data  in  32  response word; beats arrive in ascending word order.

Behaviour:
- States: IDLE, LOOKUP, MISS_REQ, MISS_DATA, FILL, REPLAY.
- Reset (reset=0, asynchronous):
  - State returns to IDLE; beat counter, addr_q, fence_pending and write_block clear to 0.
  - All outputs are 0, except that invalidate_all is 1 combinationally while reset=0.
- array_address: equals fetch_address in IDLE and LOOKUP; equals addr_q in all other states.
- IDLE:
  - fetch_valid=1 latches addr_q=fetch_address and moves to LOOKUP.
  - The array read latency is one cycle; the lookup completes in the next cycle.
- LOOKUP:
  - hit = array_tag_valid and array_tag==addr_q[31:offset_width+line_width+2].
  - hit=1: fetch_hit=1 this cycle. If a new fetch_valid is present, latch it and stay in LOOKUP (back-to-back hits give one instruction per cycle); otherwise go to IDLE.
  - hit=0: go to MISS_REQ; fetch_hit=0.
  - stall=1 in every state except IDLE and LOOKUP-with-hit.
- MISS_REQ:
  - mem_req_valid=1 and mem_req_addr={addr_q[31:offset_width+2], 0}, both held stable until mem_req_ready=1.
  - On acceptance: beat counter=0, go to MISS_DATA.
- MISS_DATA:
  - Each mem_resp_valid stores mem_resp_data into word[beat] and increments beat.
  - The beat equal to block_size-1 moves the state to FILL.
  - The counter wraps to 0.
  - mem_resp_valid is ignored in every other state.
- FILL (exactly one cycle):
  - write_in=1.
  - write_line_index=addr_q[line_width+offset_width+1:offset_width+2].
  - write_tag=addr_q tag field.
  - Next state REPLAY.
- REPLAY:
  - One cycle re-reading the array at addr_q, then go to LOOKUP, which now hits.
  - fetch_valid is not sampled until the replayed LOOKUP.
- fence_i:
  - In IDLE or LOOKUP: invalidate_all=1 for exactly one cycle, on the following cycle. Any hit reported in that same cycle stands. The next lookup sees the cache invalidated.
  - In any other state: sets fence_pending. invalidate_all is pulsed in the cycle after FILL, the cycle the state is REPLAY. The replay then misses and refills again; this is correct behaviour.
  - Simultaneous fence_i and a FILL write: the fill completes first, then the invalidate follows.
- Reset asserted mid-refill: partial block discarded, no write_in, mem_req_valid drops immediately, and late response beats are ignored.

Decomposition:
- Shared package icache_pkg holds:
  - offset_width and line_width defaults.
  - Field-extract constants for tag, line and offset positions, common with the cache array.
  - The state enumeration.
- One natural sub-module, icache_block_assembler: beat counter plus block shift/assembly register, with a done pulse.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch 0x0000_1040; memory returns 0xA0,0xA1,0xA2,0xA3.
  - Memory request: mem_req_addr=0x0000_1040.
  - Fill: write_in for one cycle with line=0x04, tag=0x4, write_block word0=0xA0 … word3=0xA3.
  - Replay: fetch_hit then asserts with stall=0.
- Back-to-back hits:
  - Stimulus: after the fill, fetch 0x1044, 0x1048, 0x104C on consecutive cycles.
  - Response: fetch_hit=1 on three consecutive cycles, no mem_req_valid.
- Conflict miss:
  - Stimulus: fetch 0x0000_1440 (same line 0x04, tag 0x5).
  - Response: miss, refill with tag=0x5; the next fetch of 0x1040 misses again.
- Backpressure:
  - Stimulus: hold mem_req_ready=0 for 5 cycles; insert 2 idle cycles between response beats.
  - Response: request address stable throughout, stall held high, block assembled correctly.
- fence_i:
  - fence_i in IDLE: invalidate_all is high for exactly one cycle.
  - fence_i during MISS_DATA: invalidate_all is pulsed in the cycle after write_in, and the replay misses.
- Async reset during the 2nd beat: all outputs drop to 0, no write_in; the next fetch starts a clean miss.
